// File: rtl/eth_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: frames are released only once complete, and an
// inter-frame gap follows each output frame. Define ETH_PKT_FIFO_STATS_EN to build the counters.
module eth_pkt_fifo #(
  parameter int AXIS_BYTES = 1,
  parameter int DEPTH      = 2048,
  parameter int IFG_CYCLES = 48
) (
  input  logic                      clk,
  input  logic                      areset,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic                      drop_pulse,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic [15:0]               stat_sent,
  output logic [15:0]               stat_dropped
);

  localparam int AW       = $clog2(DEPTH);
  localparam int DW       = 8 * AXIS_BYTES;
  localparam int EW       = 1 + AXIS_BYTES + DW;
  localparam int GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam bit HAS_GAP  = (IFG_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   wr_commit_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   rd_ptr_next;
  logic [AW:0]   pkt_count_reg;
  logic          drop_flag_reg;
  logic          ready_reg;
  logic          drop_pulse_reg;
  state_t        state_reg;
  state_t        state_next;
  logic [GW-1:0] gap_cnt_reg;
  logic [GW-1:0] gap_cnt_next;

  logic          in_accept;
  logic          space_full;
  logic          wr_en;
  logic          commit;
  logic          drop_end;
  logic          out_fire;
  logic          frame_done;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_data_reg;

  // ---------------------------------------------------------------- write side
  assign in_accept  = axis_i_tvalid & ready_reg;
  assign space_full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_en      = in_accept & ~drop_flag_reg & ~space_full;
  assign commit     = wr_en & axis_i_tlast;
  // A full buffer on the tlast beat itself ends the drop at once.
  assign drop_end   = in_accept & axis_i_tlast & (drop_flag_reg | space_full);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ready_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      wr_commit_reg  <= '0;
      drop_flag_reg  <= 1'b0;
      drop_pulse_reg <= 1'b0;
    end else begin
      ready_reg      <= 1'b1;
      drop_pulse_reg <= drop_end;
      if (drop_end) begin
        wr_ptr_reg    <= wr_commit_reg;
        drop_flag_reg <= 1'b0;
      end else if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
        if (axis_i_tlast) begin
          wr_commit_reg <= wr_ptr_reg + (AW+1)'(1);
        end
      end else if (in_accept & space_full) begin
        drop_flag_reg <= 1'b1;
      end
    end
  end

  // Read address is the next read pointer, so the registered output always tracks rd_ptr.
  // Only committed beats are ever presented, and those were written at least one edge earlier.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= {axis_i_tlast, axis_i_tkeep, axis_i_tdata};
    end
    rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
  end

  // ---------------------------------------------------------------- read side
  assign out_fire   = (state_reg == SEND) & axis_o_tready;
  assign frame_done = out_fire & rd_data_reg[EW-1];

  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    rd_ptr_next  = rd_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pkt_count_reg != '0) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
          if (rd_data_reg[EW-1]) begin
            if (HAS_GAP) begin
              state_next   = GAP;
              gap_cnt_next = GW'(GAP_LOAD);
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      GAP: begin
        // Leaving straight to SEND keeps the idle stretch at exactly IFG_CYCLES.
        if (gap_cnt_reg == '0) begin
          state_next = (pkt_count_reg != '0) ? SEND : IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg   <= IDLE;
      gap_cnt_reg <= '0;
      rd_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      gap_cnt_reg <= gap_cnt_next;
      rd_ptr_reg  <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pkt_count_reg <= '0;
    end else begin
      case ({commit, frame_done})
        2'b10:   pkt_count_reg <= pkt_count_reg + (AW+1)'(1);
        2'b01:   pkt_count_reg <= pkt_count_reg - (AW+1)'(1);
        default: pkt_count_reg <= pkt_count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign axis_i_tready = ready_reg;
  assign axis_o_tvalid = (state_reg == SEND);
  assign axis_o_tlast  = axis_o_tvalid & rd_data_reg[EW-1];
  assign axis_o_tkeep  = axis_o_tvalid ? rd_data_reg[EW-2 -: AXIS_BYTES] : '0;
  assign drop_pulse    = drop_pulse_reg;
  assign pkt_count     = pkt_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < AXIS_BYTES; gi++) begin : g_lane
      assign axis_o_tdata[8*gi +: 8] = axis_o_tvalid ? rd_data_reg[8*gi +: 8] : 8'h00;
    end
  endgenerate

`ifdef ETH_PKT_FIFO_STATS_EN
  logic [15:0] stat_sent_reg;
  logic [15:0] stat_dropped_reg;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      stat_sent_reg    <= '0;
      stat_dropped_reg <= '0;
    end else begin
      if (frame_done && stat_sent_reg != 16'hFFFF) begin
        stat_sent_reg <= stat_sent_reg + 16'd1;
      end
      if (drop_end && stat_dropped_reg != 16'hFFFF) begin
        stat_dropped_reg <= stat_dropped_reg + 16'd1;
      end
    end
  end

  assign stat_sent    = stat_sent_reg;
  assign stat_dropped = stat_dropped_reg;
`else
  assign stat_sent    = '0;
  assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo: queue-based frame model checked every cycle, plus directed frames
// with literal expectations and a randomized traffic phase.
module tb_eth_pkt_fifo;

  localparam int AB    = 2;
  localparam int DEPTH = 16;
  localparam int IFG   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          last;
    logic [AB-1:0] keep;
    logic [15:0]   data;
  } beat_t;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          i_tready;
  logic          i_tvalid = 1'b0;
  logic          i_tlast = 1'b0;
  logic [AB-1:0] i_tkeep = '0;
  logic [15:0]   i_tdata = '0;
  logic          o_tready = 1'b0;
  logic          o_tvalid;
  logic          o_tlast;
  logic [AB-1:0] o_tkeep;
  logic [15:0]   o_tdata;
  logic          drop_pulse;
  logic [CW-1:0] pkt_count;
  logic [15:0]   stat_sent;
  logic [15:0]   stat_dropped;

  eth_pkt_fifo #(.AXIS_BYTES(AB), .DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .areset(areset),
    .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid), .axis_i_tlast(i_tlast),
    .axis_i_tkeep(i_tkeep), .axis_i_tdata(i_tdata),
    .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid), .axis_o_tlast(o_tlast),
    .axis_o_tkeep(o_tkeep), .axis_o_tdata(o_tdata),
    .drop_pulse(drop_pulse), .pkt_count(pkt_count),
    .stat_sent(stat_sent), .stat_dropped(stat_dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  beat_t exp_q[$];
  beat_t cur_q[$];
  beat_t log_q[$];
  int    log_cyc[$];
  int    occ = 0, committed = 0, gap_left = 0, m_sent = 0, m_dropped = 0;
  int    since_rst = 0, cyc = 0, dp_cnt = 0;
  bit    dropping = 0, drop_exp = 0, prev_ok = 0;

  always @(negedge clk) begin : model
    beat_t b;
    cyc++;
    if (areset) begin
      chk("rst_i_tready", i_tready, 0);
      chk("rst_o_tvalid", o_tvalid, 0);
      chk("rst_o_tlast", o_tlast, 0);
      chk("rst_o_tkeep", o_tkeep, 0);
      chk("rst_o_tdata", o_tdata, 0);
      chk("rst_drop_pulse", drop_pulse, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_stats", {stat_sent, stat_dropped}, 0);
      exp_q.delete();
      cur_q.delete();
      occ = 0; committed = 0; gap_left = 0; m_sent = 0; m_dropped = 0;
      dropping = 0; drop_exp = 0; prev_ok = 0; since_rst = 0;
    end else begin
      if (since_rst < 10) since_rst++;
      if (since_rst >= 2) chk("i_tready", i_tready, 1);
      chk("pkt_count", pkt_count, committed);
      chk("drop_pulse", drop_pulse, drop_exp);
      if (drop_pulse === 1'b1) dp_cnt++;
`ifdef ETH_PKT_FIFO_STATS_EN
      chk("stat_sent", stat_sent, m_sent);
      chk("stat_dropped", stat_dropped, m_dropped);
`else
      chk("stat_sent_off", stat_sent, 0);
      chk("stat_dropped_off", stat_dropped, 0);
`endif
      // Idle for exactly IFG cycles after a frame; otherwise a stored frame must be showing.
      if (gap_left > 0) chk("gap_tvalid", o_tvalid, 0);
      else if (prev_ok) chk("tvalid_due", o_tvalid, 1);
      if (o_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL early_tvalid got=1 want=0 t=%0t", $time);
        end else begin
          chk("tdata", o_tdata, exp_q[0].data);
          chk("tkeep", o_tkeep, exp_q[0].keep);
          chk("tlast", o_tlast, exp_q[0].last);
        end
      end
      prev_ok = (committed > 0) && (gap_left <= 1);

      // events of the coming clock edge: write side first (it sees occupancy before the read)
      drop_exp = 0;
      if (gap_left > 0) gap_left--;
      if (i_tvalid && i_tready === 1'b1) begin
        b = {i_tlast, i_tkeep, i_tdata};
        if (dropping || occ == DEPTH) begin
          if (i_tlast) begin
            occ -= cur_q.size();
            cur_q.delete();
            dropping = 0;
            drop_exp = 1;
            m_dropped++;
          end else begin
            dropping = 1;
          end
        end else begin
          occ++;
          cur_q.push_back(b);
          if (i_tlast) begin
            foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
            cur_q.delete();
            committed++;
          end
        end
      end
      if (o_tvalid === 1'b1 && o_tready && exp_q.size() > 0) begin
        log_q.push_back({o_tlast, o_tkeep, o_tdata});
        log_cyc.push_back(cyc);
        occ--;
        if (exp_q[0].last) begin
          committed--;
          gap_left = IFG;
          m_sent++;
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  logic [15:0] fbuf[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_fbuf(input logic [AB-1:0] keep_last, input int idle_pct);
    for (int i = 0; i < fbuf.size(); i++) begin
      while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        i_tvalid = 1'b0;
        step();
      end
      i_tvalid = 1'b1;
      i_tdata  = fbuf[i];
      i_tlast  = (i == fbuf.size() - 1);
      i_tkeep  = i_tlast ? keep_last : '1;
      step();
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base_val, input int len);
    fbuf.delete();
    for (int i = 0; i < len; i++) fbuf.push_back(base_val + 16'(i));
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_log", (log_q.size() >= n), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  base, dp0, len;
    bit  rnd_done;
    bit  pat [6];
    pat = '{1, 0, 0, 1, 0, 1};

    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    repeat (3) step();

    // single 10-beat frame
    o_tready = 1'b1;
    base = log_q.size();
    fbuf = '{16'h00DE, 16'h00AD, 16'h00BE, 16'h00EF, 16'h00CA,
             16'h00FE, 16'h00CA, 16'h00FE, 16'h0000, 16'h0001};
    send_fbuf(2'b11, 0);
    wait_log(base + 10, 200);
    if (log_q.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        chk("A_data", log_q[base+i].data, fbuf[i]);
        chk("A_last", log_q[base+i].last, (i == 9));
      end
      chk("A_contig", log_cyc[base+9] - log_cyc[base], 9);
    end
    repeat (6) step();
    chk("A_pkt_count", pkt_count, 0);

    // two 3-beat frames: gap of exactly IFG idle cycles
    base = log_q.size();
    fill(16'hB100, 3); send_fbuf(2'b11, 0);
    fill(16'hB200, 3); send_fbuf(2'b11, 0);
    wait_log(base + 6, 200);
    if (log_q.size() >= base + 6) begin
      chk("B_gap", log_cyc[base+3] - log_cyc[base+2] - 1, 4);
      chk("B_f2_first", log_q[base+3].data, 16'hB200);
    end

    // overflow drop: A stored, B dropped, C stored
    repeat (8) step();
    o_tready = 1'b0;
    dp0  = dp_cnt;
    base = log_q.size();
    fill(16'hA000, 12); send_fbuf(2'b11, 0);
    fill(16'hB000, 8);  send_fbuf(2'b11, 0);
    repeat (3) step();
    chk("C_drop_pulses", dp_cnt - dp0, 1);
    chk("C_pkt_count_1", pkt_count, 1);
`ifdef ETH_PKT_FIFO_STATS_EN
    chk("C_stat_dropped", stat_dropped, 1);
`endif
    fill(16'hC000, 4); send_fbuf(2'b11, 0);
    step();
    chk("C_pkt_count_2", pkt_count, 2);
    o_tready = 1'b1;
    wait_log(base + 16, 200);
    repeat (30) step();
    chk("C_beats", log_q.size() - base, 16);
    if (log_q.size() >= base + 16) begin
      for (int i = 0; i < 12; i++) chk("C_A_data", log_q[base+i].data, 16'hA000 + 16'(i));
      for (int i = 0; i < 4; i++)  chk("C_C_data", log_q[base+12+i].data, 16'hC000 + 16'(i));
    end

    // output stalls 1,0,0,1,0,1...
    base = log_q.size();
    fill(16'hD000, 6);
    fork
      send_fbuf(2'b11, 0);
      begin
        for (int j = 0; j < 80 && log_q.size() < base + 6; j++) begin
          o_tready = pat[j % 6];
          step();
        end
      end
    join
    o_tready = 1'b1;
    wait_log(base + 6, 100);
    if (log_q.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("D_data", log_q[base+i].data, 16'hD000 + 16'(i));

    // partial tkeep on the last beat
    base = log_q.size();
    fbuf = '{16'hE001, 16'hE002};
    send_fbuf(2'b01, 0);
    wait_log(base + 2, 100);
    if (log_q.size() >= base + 2) begin
      chk("E_keep_last", log_q[base+1].keep, 2'b01);
      chk("E_last", log_q[base+1].last, 1);
    end

    // randomized traffic
    rnd_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          len = $urandom_range(1, 20);
          fbuf.delete();
          for (int i = 0; i < len; i++) fbuf.push_back(16'($urandom));
          send_fbuf(AB'($urandom_range(1, 3)), 30);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          o_tready = ($urandom_range(0, 99) < 60);
          step();
        end
      end
    join
    o_tready = 1'b1;
    for (int k = 0; k < 4000 && exp_q.size() != 0; k++) step();
    repeat (8) step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_pkt_count", pkt_count, 0);

    // reset while a frame is mid-output and another is mid-input
    o_tready = 1'b0;
    fill(16'hF000, 5); send_fbuf(2'b11, 0);
    o_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_tvalid = 1'b1; i_tlast = 1'b0; i_tkeep = '1; i_tdata = 16'hF100 + 16'(i);
      step();
    end
    #1 areset = 1'b1;
    #1;
    chk("R_o_tvalid", o_tvalid, 0);
    chk("R_o_tdata", o_tdata, 0);
    chk("R_o_tlast", o_tlast, 0);
    chk("R_o_tkeep", o_tkeep, 0);
    chk("R_i_tready", i_tready, 0);
    chk("R_pkt_count", pkt_count, 0);
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    repeat (3) step();
    chk("R_pkt_count_after", pkt_count, 0);
    base = log_q.size();
    fill(16'h5A00, 6); send_fbuf(2'b11, 0);
    wait_log(base + 6, 100);
    repeat (20) step();
    chk("R_beats", log_q.size() - base, 6);
    if (log_q.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("R_data", log_q[base+i].data, 16'h5A00 + 16'(i));

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_pkt_fifo.md
Name: eth_pkt_fifo

Overview:
- Store-and-forward AXI-Stream packet FIFO for the Ethernet TX path.
- Sits between the frame builder (eth_framer) and rmii_to_axis, replacing the plain axis_fifo.
- Releases a frame only once its tlast beat is stored, so the MAC never underruns mid-frame.
- Drops frames that overflow the buffer, and enforces a programmable inter-frame gap between released frames.

Parameters:
- AXIS_BYTES, 1, data width in bytes; tdata is 8*AXIS_BYTES bits.
- DEPTH, 2048, buffer depth in beats; must be a power of two, >= 4.
- IFG_CYCLES, 48, idle cycles forced after each output tlast (48 = 96 bit-times at RMII 2 bits/clk); 0 disables the gap.

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tlast  in  1  input end of frame
- axis_i_tkeep  in  AXIS_BYTES  byte enables; only meaningful on the tlast beat
- axis_i_tdata  in  8*AXIS_BYTES  input data
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  output end of frame
- axis_o_tkeep  out  AXIS_BYTES  output byte enables
- axis_o_tdata  out  8*AXIS_BYTES  output data
- drop_pulse  out  1  one-cycle pulse when a frame is discarded
- pkt_count  out  $clog2(DEPTH)+1  committed frames currently stored
- stat_sent  out  16  frames fully output (optional feature)
- stat_dropped  out  16  frames dropped (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - all pointers, counters and FSM state cleared.
  - axis_i_tready=0, axis_o_tvalid=0, axis_o_tlast=0, axis_o_tkeep=0, axis_o_tdata=0.
  - drop_pulse=0, pkt_count=0, stats=0.
  - axis_i_tready goes to 1 on the first clk edge after deassert and then stays 1; the input side never back-pressures.
- Storage: each entry holds {tlast, tkeep, tdata}. Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full/empty use the MSB compare.
- Write side keeps a write pointer (wr_ptr) and a commit pointer (wr_commit):
  - Accepted beat with space: stored at wr_ptr, wr_ptr++.
  - Accepted beat with tlast and no drop flag: wr_commit <= wr_ptr+1, pkt_count++.
  - Accepted beat with no space (wr_ptr - rd_ptr == DEPTH): set drop flag and do not store the beat.
  - While drop flag is set: discard every beat. On the tlast beat: wr_ptr <= wr_commit, clear drop flag, drop_pulse=1 for one cycle. A frame longer than DEPTH is always dropped.
  - Commit on the same cycle as a read-side frame completion: pkt_count is unchanged (+1-1).
- Read side FSM:
  - IDLE: when pkt_count>0, load the first beat; axis_o_tvalid=1 no later than 2 cycles after the commit edge. Go to SEND.
  - SEND: present beats from rd_ptr. A handshake advances rd_ptr. Beats are back-to-back while axis_o_tready=1, with no valid bubbles inside a frame. On the tlast handshake: pkt_count--, then go to GAP if IFG_CYCLES>0, else IDLE.
  - GAP: axis_o_tvalid=0 for exactly IFG_CYCLES cycles, then IDLE.
  - axis_o_tvalid=1 with tready=0 holds tdata/tkeep/tlast stable.
  - The read side never reads past wr_commit, so uncommitted or dropped beats are never visible.
- Space check uses rd_ptr (frame-granular release is done by the read FSM only), so freed space becomes available one cycle after the read handshake.
- Simultaneous read and write to the same address cannot occur: reads are bounded by wr_commit.
- pkt_count saturation is impossible: frames are >= 1 beat, so the maximum is DEPTH.

Optional Feature:
- Macro: ETH_PKT_FIFO_STATS_EN.
- Defined:
  - stat_sent increments on each output tlast handshake.
  - stat_dropped increments with each drop_pulse.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared only by areset.
- Undefined: stat_sent and stat_dropped are tied to 0 and no counter logic is built. drop_pulse and pkt_count are unaffected.

Test Plan:
- DEPTH=16, IFG_CYCLES=4. Write a 10-beat frame DE,AD,BE,EF,CA,FE,CA,FE,00,01 with tready=1 -> no axis_o_tvalid before the tlast commit. Output is 10 contiguous beats, identical, tlast on beat 10. pkt_count goes 1->0.
- Two 3-beat frames back-to-back, IFG_CYCLES=4, tready=1 -> exactly 4 tvalid=0 cycles between frame 1 tlast and frame 2 first beat.
- DEPTH=16: write 12-beat frame A (unread, tready=0), then 8-beat frame B -> B dropped, drop_pulse once at B's tlast, stat_dropped=1, pkt_count=1. Then write 4-beat frame C -> C stored; output is A then C only.
- Output tready toggled 1,0,0,1,0,1… during a 6-beat frame -> data/tlast/tkeep stable while stalled, no lost or duplicated beats.
- AXIS_BYTES=2: tlast beat with tkeep=2'b01 -> tkeep=2'b01 reproduced on output tlast beat.
- Assert areset mid-frame on both sides -> all outputs 0 immediately; after release pkt_count=0, and a new frame passes intact with no stale data.
